// File: rtl/adc_uart_reporter_if.sv
// Port bundle between the ADC sampling stage and the UART report generator:
// the eight snapshot sources, the start/busy/done handshake and the serial line.
interface adc_uart_reporter_if;
    logic       start;
    logic [7:0] ch1_val;
    logic [7:0] ch2_val;
    logic [7:0] ch3_val;
    logic [7:0] ch4_val;
    logic [7:0] ch1_max;
    logic [7:0] ch2_max;
    logic [7:0] ch3_max;
    logic [7:0] ch4_max;
    logic       tx;
    logic       busy;
    logic       frame_done;

    modport master (
        output start,
        output ch1_val, ch2_val, ch3_val, ch4_val,
        output ch1_max, ch2_max, ch3_max, ch4_max,
        input  tx, busy, frame_done
    );

    modport slave (
        input  start,
        input  ch1_val, ch2_val, ch3_val, ch4_val,
        input  ch1_max, ch2_max, ch3_max, ch4_max,
        output tx, busy, frame_done
    );
endinterface

// File: rtl/adc_uart_reporter.sv
// Snapshots four live ADC channels and their running maxima on request and
// sends them as a 34-byte ASCII hex report over an 8N1 UART line.
module adc_uart_reporter #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int BAUD     = 9600,
    parameter int BAUD_DIV = CLK_HZ / BAUD
) (
    input  logic                clock,
    input  logic                reset,
    adc_uart_reporter_if.slave  bus
);

    localparam int              CNT_W     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [5:0]      LAST_BYTE = 6'd33;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e           state_q, state_d;
    logic [5:0]       byte_idx_q, byte_idx_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic [7:0]       snap_val_q [4];
    logic [7:0]       snap_val_d [4];
    logic [7:0]       snap_max_q [4];
    logic [7:0]       snap_max_d [4];
    logic [7:0]       cur_byte;
    logic [1:0]       grp;
    logic             baud_end;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    // Byte layout: eight bytes per channel "n=VV/MM " followed by CR LF.
    always_comb begin
        grp = byte_idx_q[4:3];
        if (byte_idx_q[5]) begin
            cur_byte = byte_idx_q[0] ? 8'h0A : 8'h0D;
        end else begin
            unique case (byte_idx_q[2:0])
                3'd0:    cur_byte = 8'h31 + {6'b0, grp};
                3'd1:    cur_byte = 8'h3D;
                3'd2:    cur_byte = hex_ascii(snap_val_q[grp][7:4]);
                3'd3:    cur_byte = hex_ascii(snap_val_q[grp][3:0]);
                3'd4:    cur_byte = 8'h2F;
                3'd5:    cur_byte = hex_ascii(snap_max_q[grp][7:4]);
                3'd6:    cur_byte = hex_ascii(snap_max_q[grp][3:0]);
                default: cur_byte = 8'h20;
            endcase
        end
    end

    assign baud_end = (baud_cnt_q == BAUD_LAST);

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        bit_cnt_d    = bit_cnt_q;
        baud_cnt_d   = baud_cnt_q;
        tx_d         = tx_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        snap_val_d   = snap_val_q;
        snap_max_d   = snap_max_q;

        if (state_q != IDLE) begin
            baud_cnt_d = baud_end ? '0 : baud_cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d       = START;
                    busy_d        = 1'b1;
                    tx_d          = 1'b0;
                    baud_cnt_d    = '0;
                    byte_idx_d    = '0;
                    bit_cnt_d     = '0;
                    snap_val_d[0] = bus.ch1_val;
                    snap_val_d[1] = bus.ch2_val;
                    snap_val_d[2] = bus.ch3_val;
                    snap_val_d[3] = bus.ch4_val;
                    snap_max_d[0] = bus.ch1_max;
                    snap_max_d[1] = bus.ch2_max;
                    snap_max_d[2] = bus.ch3_max;
                    snap_max_d[3] = bus.ch4_max;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    tx_d      = cur_byte[0];
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = cur_byte[bit_cnt_q + 3'd1];
                    end
                end
            end
            STOP: begin
                if (baud_end) begin
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d      = IDLE;
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                        byte_idx_d   = '0;
                    end else begin
                        state_d    = START;
                        byte_idx_d = byte_idx_q + 6'd1;
                        tx_d       = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            byte_idx_q   <= '0;
            bit_cnt_q    <= '0;
            baud_cnt_q   <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            bit_cnt_q    <= bit_cnt_d;
            baud_cnt_q   <= baud_cnt_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // NOTE: snapshot storage is reloaded on every accept before use, so it carries no reset.
    always_ff @(posedge clock) begin
        snap_val_q <= snap_val_d;
        snap_max_q <= snap_max_d;
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_adc_uart_reporter.sv
// Bench for adc_uart_reporter: mid-bit UART receiver feeding a byte scoreboard,
// table-driven report frames plus snapshot, busy-guard, back-to-back and reset cases.
module tb_adc_uart_reporter;

    localparam int CLK_HZ    = 80;
    localparam int BAUD      = 10;
    localparam int BIT_CYC   = 8;
    localparam int FRAME_CYC = 340 * BIT_CYC;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    adc_uart_reporter_if bus ();

    adc_uart_reporter #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] vals;   // ch1 in [31:24] .. ch4 in [7:0]
        logic [31:0] maxs;
        string       text;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          busy_rise_cyc = 0;
    int          done_cnt = 0;
    int          rx_bytes = 0;
    logic        busy_prev = 1'b0;
    logic [7:0]  exp_q [$];

    logic        rx_active = 1'b0;
    int          rx_cnt = 0;
    logic [7:0]  rx_shift = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic got_byte(input logic [7:0] b);
        logic [7:0] e;
        rx_bytes++;
        if (exp_q.size() == 0) begin
            check("rx_unexpected_byte", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("rx_byte", {24'h0, b}, {24'h0, e});
        end
    endtask

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (bus.frame_done === 1'b1) done_cnt++;
        if (bus.busy === 1'b1 && busy_prev !== 1'b1) busy_rise_cyc = cyc;
        busy_prev = bus.busy;
    end

    // UART receiver: start edge found at rx_cnt 0, all bits sampled mid-bit.
    always @(negedge clock) begin
        if (reset) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (bus.tx === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == 4) begin
                check("rx_start_bit", {31'h0, bus.tx}, 32'd0);
                if (bus.tx !== 1'b0) rx_active = 1'b0;
            end else if (rx_cnt >= 12 && rx_cnt <= 68 && ((rx_cnt - 4) % 8) == 0) begin
                rx_shift = {bus.tx, rx_shift[7:1]};
            end else if (rx_cnt == 76) begin
                check("rx_stop_bit", {31'h0, bus.tx}, 32'd1);
                got_byte(rx_shift);
                rx_active = 1'b0;
            end
        end
    end

    task automatic set_inputs(input logic [31:0] v, input logic [31:0] m);
        bus.ch1_val = v[31:24]; bus.ch2_val = v[23:16];
        bus.ch3_val = v[15:8];  bus.ch4_val = v[7:0];
        bus.ch1_max = m[31:24]; bus.ch2_max = m[23:16];
        bus.ch3_max = m[15:8];  bus.ch4_max = m[7:0];
    endtask

    task automatic push_expected(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    // One-cycle start pulse; busy and the start bit must appear right after the accept edge.
    task automatic start_frame(input string tag);
        @(negedge clock); #1;
        bus.start = 1'b1;
        @(posedge clock); #1;
        check({tag, "_accept_busy"}, {31'h0, bus.busy}, 32'd1);
        check({tag, "_accept_tx_low"}, {31'h0, bus.tx}, 32'd0);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int lat);
        int n;
        n   = 0;
        lat = -1;
        while (n < budget) begin
            @(negedge clock);
            n++;
            if (bus.frame_done === 1'b1) begin
                lat = cyc - busy_rise_cyc;
                check({tag, "_done_busy_low"}, {31'h0, bus.busy}, 32'd0);
                break;
            end
        end
        if (lat < 0) check({tag, "_frame_done_timeout"}, 32'd0, 32'd1);
    endtask

    vec_t vecs [4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int activity;
        int d0;
        int b0;

        vecs[0] = '{32'h3A009F7E, 32'hFF05A080, "1=3A/FF 2=00/05 3=9F/A0 4=7E/80 \r\n"};
        vecs[1] = '{32'h00000000, 32'h00000000, "1=00/00 2=00/00 3=00/00 4=00/00 \r\n"};
        vecs[2] = '{32'h12345678, 32'h9ABCDEF0, "1=12/9A 2=34/BC 3=56/DE 4=78/F0 \r\n"};
        vecs[3] = '{32'hFFFFFFFF, 32'h0AB0C9D1, "1=FF/0A 2=FF/B0 3=FF/C9 4=FF/D1 \r\n"};

        bus.start = 1'b0;
        set_inputs(32'h0, 32'h0);

        // Reset held for three cycles
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("reset_tx", {31'h0, bus.tx}, 32'd1);
            check("reset_busy", {31'h0, bus.busy}, 32'd0);
            check("reset_frame_done", {31'h0, bus.frame_done}, 32'd0);
        end
        #1 reset = 1'b0;
        activity = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) activity++;
        end
        check("idle_no_activity", 32'(activity), 32'd0);

        // Table-driven frames
        for (int v = 0; v < 4; v++) begin
            d0 = done_cnt;
            @(negedge clock); #1;
            set_inputs(vecs[v].vals, vecs[v].maxs);
            push_expected(vecs[v].text);
            start_frame("vec");
            wait_done("vec", FRAME_CYC + 200, lat);
            check("vec_done_latency", 32'(lat), 32'(FRAME_CYC));
            repeat (20) @(negedge clock);
            check("vec_all_bytes_seen", 32'(exp_q.size()), 32'd0);
            check("vec_one_frame_done", 32'(done_cnt - d0), 32'd1);
        end

        // Snapshot isolation: inputs change during byte 5
        @(negedge clock); #1;
        set_inputs(vecs[0].vals, vecs[0].maxs);
        push_expected(vecs[0].text);
        start_frame("snap");
        repeat (5 * 10 * BIT_CYC + 40) @(negedge clock);
        #1 set_inputs(32'h11111111, 32'h11111111);
        wait_done("snap", FRAME_CYC, lat);
        repeat (20) @(negedge clock);
        check("snap_all_bytes_seen", 32'(exp_q.size()), 32'd0);

        // Busy guard: extra start pulses mid-frame are ignored
        d0 = done_cnt;
        b0 = rx_bytes;
        @(negedge clock); #1;
        set_inputs(vecs[2].vals, vecs[2].maxs);
        push_expected(vecs[2].text);
        start_frame("guard");
        repeat (99) @(negedge clock);
        #1 bus.start = 1'b1;
        @(negedge clock); #1 bus.start = 1'b0;
        repeat (1399) @(negedge clock);
        #1 bus.start = 1'b1;
        @(negedge clock); #1 bus.start = 1'b0;
        wait_done("guard", FRAME_CYC, lat);
        repeat (300) @(negedge clock);
        check("guard_single_done", 32'(done_cnt - d0), 32'd1);
        check("guard_byte_count", 32'(rx_bytes - b0), 32'd34);
        check("guard_idle_after", {31'h0, bus.busy}, 32'd0);

        // Back-to-back frames with start held high
        d0 = done_cnt;
        @(negedge clock); #1;
        set_inputs(vecs[3].vals, vecs[3].maxs);
        push_expected(vecs[3].text);
        push_expected(vecs[3].text);
        bus.start = 1'b1;
        @(posedge clock); #1;
        check("b2b_first_accept", {31'h0, bus.busy}, 32'd1);
        wait_done("b2b1", FRAME_CYC + 10, lat);
        check("b2b1_latency", 32'(lat), 32'(FRAME_CYC));
        check("b2b_gap_tx_high", {31'h0, bus.tx}, 32'd1);
        @(posedge clock); #1;
        check("b2b_restart_busy", {31'h0, bus.busy}, 32'd1);
        check("b2b_restart_tx_low", {31'h0, bus.tx}, 32'd0);
        bus.start = 1'b0;
        wait_done("b2b2", FRAME_CYC + 10, lat);
        check("b2b2_latency", 32'(lat), 32'(FRAME_CYC));
        repeat (20) @(negedge clock);
        check("b2b_done_count", 32'(done_cnt - d0), 32'd2);
        check("b2b_all_bytes_seen", 32'(exp_q.size()), 32'd0);

        // Reset during the DATA bits of byte 12
        d0 = done_cnt;
        @(negedge clock); #1;
        set_inputs(vecs[1].vals, vecs[1].maxs);
        push_expected(vecs[1].text);
        start_frame("rst");
        repeat (12 * 10 * BIT_CYC + 30) @(negedge clock);
        check("rst_pre_busy", {31'h0, bus.busy}, 32'd1);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        check("rst_tx_high", {31'h0, bus.tx}, 32'd1);
        check("rst_busy_low", {31'h0, bus.busy}, 32'd0);
        @(negedge clock); #1;
        reset = 1'b0;
        exp_q.delete();
        repeat (300) @(negedge clock);
        check("rst_no_frame_done", 32'(done_cnt - d0), 32'd0);
        check("rst_line_idle", {31'h0, bus.tx}, 32'd1);
        set_inputs(vecs[0].vals, vecs[0].maxs);
        push_expected(vecs[0].text);
        start_frame("post_rst");
        wait_done("post_rst", FRAME_CYC + 10, lat);
        check("post_rst_latency", 32'(lat), 32'(FRAME_CYC));
        repeat (20) @(negedge clock);
        check("post_rst_all_bytes_seen", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
